// File: rtl/mano_seq_ctrl_pkg.sv
// Shared constants and types for the basic-computer timing/control sequencer.
// Opcode and T-index values follow the classic Mano encoding.
package mano_ctrl_pkg;

  localparam int SC_W = 3;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_LDA = 3'd2;
  localparam logic [2:0] OP_STA = 3'd3;
  localparam logic [2:0] OP_BUN = 3'd4;
  localparam logic [2:0] OP_BSA = 3'd5;
  localparam logic [2:0] OP_ISZ = 3'd6;
  localparam logic [2:0] OP_IO  = 3'd7;

  localparam logic [SC_W-1:0] T0 = 3'd0;
  localparam logic [SC_W-1:0] T1 = 3'd1;
  localparam logic [SC_W-1:0] T2 = 3'd2;
  localparam logic [SC_W-1:0] T3 = 3'd3;
  localparam logic [SC_W-1:0] T4 = 3'd4;
  localparam logic [SC_W-1:0] T5 = 3'd5;

  localparam int B_CLA = 11;
  localparam int B_CMA = 9;
  localparam int B_INC = 5;
  localparam int B_HLT = 0;

  // Datapath strobes produced in a single cycle; memory requests are kept apart
  // because they are level signals rather than one-shot strobes.
  typedef struct packed {
    logic ar_ld_pc;
    logic ar_ld_ir;
    logic ar_ld_mem;
    logic pc_inc;
    logic pc_ld;
    logic ir_ld;
    logic dr_ld;
    logic op_and;
    logic op_add;
    logic op_lda;
    logic op_clr;
    logic op_com;
    logic op_inc;
  } strobe_t;

  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    onehot8 = 8'h01 << idx;
  endfunction

endpackage

// File: rtl/mano_seq_ctrl_if.sv
// Bundle of instruction, memory handshake, timing and strobe signals between
// the sequencer (master) and the accumulator datapath/memory (slave).
interface mano_seq_ctrl_if;

  logic        start;
  logic [15:0] IR;
  logic        mem_ack;

  logic [7:0]  T;
  logic [7:0]  D;
  logic        J;
  logic        S;

  logic        AR_LD_PC;
  logic        AR_LD_IR;
  logic        AR_LD_MEM;
  logic        PC_INC;
  logic        PC_LD;
  logic        IR_LD;
  logic        DR_LD;
  logic        MEM_RD;
  logic        MEM_WR;
  logic        AND;
  logic        ADD;
  logic        LDA;
  logic        CLR;
  logic        COM;
  logic        INC;
  logic        ERR;

  modport master (
    input  start, IR, mem_ack,
    output T, D, J, S,
    output AR_LD_PC, AR_LD_IR, AR_LD_MEM, PC_INC, PC_LD, IR_LD, DR_LD,
    output MEM_RD, MEM_WR, AND, ADD, LDA, CLR, COM, INC, ERR
  );

  modport slave (
    output start, IR, mem_ack,
    input  T, D, J, S,
    input  AR_LD_PC, AR_LD_IR, AR_LD_MEM, PC_INC, PC_LD, IR_LD, DR_LD,
    input  MEM_RD, MEM_WR, AND, ADD, LDA, CLR, COM, INC, ERR
  );

endinterface

// File: rtl/mano_seq_ctrl_counter.sv
// Sequence counter SC with clear/increment/hold control and one-hot T decode.
// Only T0..T5 are legal; any other count is pulled back to 0.
module mano_seq_counter
  import mano_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  input  logic            clr,
  output logic [SC_W-1:0] sc,
  output logic [7:0]      t
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc <= T0;
    end else if (clr || (sc > T5)) begin
      sc <= T0;
    end else if (inc) begin
      sc <= (sc == T5) ? T0 : sc + SC_W'(1);
    end
  end

  always_comb begin
    t = (sc > T5) ? 8'h00 : onehot8(sc);
  end

endmodule

// File: rtl/mano_seq_ctrl.sv
// Timing and control sequencer: run flip-flop, indirect latch, ack timeout and
// the per-T-state strobe decode for fetch, indirect, memory-ref and reg-ref.
module mano_seq_ctrl
  import mano_ctrl_pkg::*;
#(
  parameter int ACK_TIMEOUT = 0,
  parameter int TO_W        = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mano_seq_ctrl_if.master      bus
);

  logic [SC_W-1:0] sc;
  logic [7:0]      t;
  logic [7:0]      d;
  logic            s_q;
  logic            j_q;
  logic            err_q;
  logic [TO_W-1:0] wait_cnt;

  strobe_t         stb;
  logic            mem_rd;
  logic            mem_wr;
  logic            mem_busy;
  logic            sc_inc;
  logic            sc_clr;
  logic            halt;
  logic            timeout;
  logic            unused_ir_bits;

  assign unused_ir_bits = ^{bus.IR[10], bus.IR[8:6], bus.IR[4:1]};

  mano_seq_counter u_sc (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (sc_inc),
    .clr   (sc_clr),
    .sc    (sc),
    .t     (t)
  );

  always_comb begin
    d = onehot8(bus.IR[14:12]);
  end

  // Strobes fire only in the cycle SC leaves a state; memory states wait for ack.
  always_comb begin
    stb    = '0;
    mem_rd = 1'b0;
    mem_wr = 1'b0;
    sc_inc = 1'b0;
    sc_clr = 1'b0;
    halt   = 1'b0;
    if (!s_q) begin
      sc_clr = 1'b1;
    end else begin
      case (sc)
        T0: begin
          stb.ar_ld_pc = 1'b1;
          sc_inc       = 1'b1;
        end
        T1: begin
          mem_rd = 1'b1;
          if (bus.mem_ack) begin
            stb.ir_ld  = 1'b1;
            stb.pc_inc = 1'b1;
            sc_inc     = 1'b1;
          end
        end
        T2: begin
          stb.ar_ld_ir = 1'b1;
          sc_inc       = 1'b1;
        end
        T3: begin
          if (d[OP_IO]) begin
            if (!j_q) begin
              stb.op_clr = bus.IR[B_CLA];
              stb.op_com = bus.IR[B_CMA];
              stb.op_inc = bus.IR[B_INC];
              halt       = bus.IR[B_HLT];
            end
            sc_clr = 1'b1;
          end else if (j_q) begin
            mem_rd = 1'b1;
            if (bus.mem_ack) begin
              stb.ar_ld_mem = 1'b1;
              sc_inc        = 1'b1;
            end
          end else begin
            sc_inc = 1'b1;
          end
        end
        T4: begin
          if (d[OP_AND] || d[OP_ADD] || d[OP_LDA]) begin
            mem_rd = 1'b1;
            if (bus.mem_ack) begin
              stb.dr_ld = 1'b1;
              sc_inc    = 1'b1;
            end
          end else if (d[OP_STA]) begin
            mem_wr = 1'b1;
            if (bus.mem_ack) begin
              sc_clr = 1'b1;
            end
          end else if (d[OP_BUN]) begin
            stb.pc_ld = 1'b1;
            sc_clr    = 1'b1;
          end else begin
            sc_clr = 1'b1;
          end
        end
        T5: begin
          stb.op_and = d[OP_AND];
          stb.op_add = d[OP_ADD];
          stb.op_lda = d[OP_LDA];
          sc_clr     = 1'b1;
        end
        default: begin
          sc_clr = 1'b1;
        end
      endcase
    end

    mem_busy = mem_rd || mem_wr;
    timeout  = (ACK_TIMEOUT != 0) && mem_busy && !bus.mem_ack &&
               (wait_cnt == TO_W'(ACK_TIMEOUT - 1));
    if (timeout) begin
      sc_clr = 1'b1;
    end
  end

  // Run flip-flop: a timeout or HLT stops the machine; start is honoured only
  // from the stopped state and only while no timeout error is latched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q   <= 1'b0;
      err_q <= 1'b0;
    end else begin
      if (timeout || halt) begin
        s_q <= 1'b0;
      end else if (!s_q && bus.start && !err_q) begin
        s_q <= 1'b1;
      end
      if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j_q <= 1'b0;
    end else if (s_q && (sc == T2)) begin
      j_q <= bus.IR[15];
    end
  end

  // Counts unacknowledged cycles of the current memory access only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (mem_busy && !bus.mem_ack && !timeout) begin
      wait_cnt <= wait_cnt + TO_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  assign bus.T         = t;
  assign bus.D         = d;
  assign bus.J         = j_q;
  assign bus.S         = s_q;
  assign bus.ERR       = err_q;
  assign bus.MEM_RD    = mem_rd;
  assign bus.MEM_WR    = mem_wr;
  assign bus.AR_LD_PC  = stb.ar_ld_pc;
  assign bus.AR_LD_IR  = stb.ar_ld_ir;
  assign bus.AR_LD_MEM = stb.ar_ld_mem;
  assign bus.PC_INC    = stb.pc_inc;
  assign bus.PC_LD     = stb.pc_ld;
  assign bus.IR_LD     = stb.ir_ld;
  assign bus.DR_LD     = stb.dr_ld;
  assign bus.AND       = stb.op_and;
  assign bus.ADD       = stb.op_add;
  assign bus.LDA       = stb.op_lda;
  assign bus.CLR       = stb.op_clr;
  assign bus.COM       = stb.op_com;
  assign bus.INC       = stb.op_inc;

endmodule
